// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master: turns a cmd/rsp stream into AXI4-Lite reads and writes.
// Includes a sticky stall watchdog that flags, but never aborts, a hung transaction.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// WR     | AW and W channels in flight, each drops after its own handshake
// WR_B   | BREADY high, waiting for the write response
// AR     | ARVALID high, waiting for ARREADY
// RD     | RREADY high, waiting for read data
// RSP    | rsp_valid high, holding the response until rsp_ready
module axi_lite_master_cmd #(
  parameter int         C_M_AXI_ADDR_WIDTH = 32,
  parameter int         C_M_AXI_DATA_WIDTH = 32,
  parameter logic [2:0] PROT               = 3'b000,
  parameter int         TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_write,
  output logic                            busy,
  output logic                            timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WR_B = 3'd2,
    S_AR   = 3'd3,
    S_RD   = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  localparam logic [31:0] C_TO = 32'(TIMEOUT_CYCLES);

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic                              w_accept;
  logic                              w_aw_hs;
  logic                              w_w_hs;
  logic                              w_wd_active;

  logic                              r_cmd_ready;
  logic                              r_awvalid;
  logic                              r_wvalid;
  logic                              r_write;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
  logic [1:0]                        r_rsp_resp;
  logic [31:0]                       r_wd_cnt;
  logic                              r_timeout;

  assign w_aw_hs     = r_awvalid && M_AXI_AWREADY;
  assign w_w_hs      = r_wvalid && M_AXI_WREADY;
  assign w_wd_active = (r_state == S_WR) || (r_state == S_WR_B) ||
                       (r_state == S_AR) || (r_state == S_RD);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = cmd_write ? S_WR : S_AR;
        end
      end
      // a channel whose VALID already dropped has completed its handshake
      S_WR: begin
        if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) begin
          w_state_nxt = S_WR_B;
        end
      end
      S_WR_B: if (M_AXI_BVALID)  w_state_nxt = S_RSP;
      S_AR:   if (M_AXI_ARREADY) w_state_nxt = S_RD;
      S_RD:   if (M_AXI_RVALID)  w_state_nxt = S_RSP;
      S_RSP:  if (rsp_ready)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);

      if (w_accept) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_write   <= cmd_write;
        r_awvalid <= cmd_write;
        r_wvalid  <= cmd_write;
      end else begin
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
      end

      if ((r_state == S_WR_B) && M_AXI_BVALID) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= M_AXI_BRESP;
      end else if ((r_state == S_RD) && M_AXI_RVALID) begin
        r_rsp_rdata <= M_AXI_RDATA;
        r_rsp_resp  <= M_AXI_RRESP;
      end

      // saturating up-count; the flag rises on the edge the count reaches the limit
      if (w_accept) begin
        r_wd_cnt  <= '0;
        r_timeout <= 1'b0;
      end else if (w_wd_active && (C_TO != 32'd0) && (r_wd_cnt != C_TO)) begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
        if (r_wd_cnt == C_TO - 32'd1) r_timeout <= 1'b1;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = (r_state == S_RSP);
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_write     = r_write;
  assign busy          = (r_state != S_IDLE);
  assign timeout       = r_timeout;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = PROT;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = (r_state == S_WR_B);
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = PROT;
  assign M_AXI_ARVALID = (r_state == S_AR);
  assign M_AXI_RREADY  = (r_state == S_RD);

endmodule

// File: doc/axi_lite_master_cmd.md
Name: axi_lite_master_cmd

Overview:
Single-outstanding AXI4-Lite master that converts a simple command/response stream into AXI4-Lite read and write transactions.
It is the initiator counterpart to the team's AXI-Lite register-file slave.
It lets fabric logic, such as a sequencer, self-test engine or loopback bench, drive any AXI4-Lite slave (for example the 16-register regfile) without the PCIe bridge.
It runs one transaction at a time and includes a stall watchdog.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, address width of the command and of AWADDR/ARADDR.
C_M_AXI_DATA_WIDTH, 32, data width; fixed at 32 (only legal value).
PROT, 3'b000, constant driven on AWPROT/ARPROT.
TIMEOUT_CYCLES, 1024, stall limit in clocks; 0 disables the watchdog.

Ports:
M_AXI_ACLK  in  1  clock.
M_AXI_ARESETN  in  1  asynchronous active-low reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  ADDR_WIDTH  byte address.
cmd_wdata  in  32  write data.
cmd_wstrb  in  4  write strobes.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accepted.
rsp_rdata  out  32  read data; 0 for writes.
rsp_resp  out  2  BRESP or RRESP.
rsp_write  out  1  echo of cmd_write.
busy  out  1  high whenever state is not IDLE.
timeout  out  1  sticky stall flag.
M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in.
M_AXI_WDATA/WSTRB/WVALID out, WREADY in.
M_AXI_BRESP/BVALID in, BREADY out.
M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in.
M_AXI_RDATA/RRESP/RVALID in, RREADY out.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - All VALIDs and READYs are 0, rsp_valid=0, busy=0, timeout=0.
  - Address, data and response registers are 0.
  - Reset mid-transaction drops every VALID immediately; no completion response is issued.
- FSM states are IDLE, WR, WR_B, AR, RD, RSP.
- IDLE:
  - cmd_ready=1 (registered; high only in IDLE).
  - On accept, capture addr/wdata/wstrb/write, clear timeout, then go to WR if cmd_write else AR.
- WR:
  - AWVALID and WVALID are both 1 on the first cycle after accept.
  - Each drops independently in the cycle after its own handshake (AWVALID&&AWREADY, WVALID&&WREADY); the two handshakes may complete in any order or in the same cycle.
  - When both are done, go to WR_B.
- WR_B:
  - BREADY=1.
  - On BVALID, capture BRESP, set rsp_rdata=0, go to RSP.
  - BVALID seen while BREADY=0 is ignored.
- AR:
  - ARVALID=1 starting the cycle after accept.
  - On ARREADY, go to RD.
- RD:
  - RREADY=1.
  - On RVALID, capture RDATA/RRESP, go to RSP.
- RSP:
  - rsp_valid=1; rsp_* stay stable until rsp_ready.
  - On rsp_ready, go to IDLE; cmd_ready=1 the next cycle.
- AXI address and data are the captured values held constant while VALID is high; VALID never drops before its handshake.
- Minimum latency with zero-wait slave and rsp_ready=1:
  - Write: accept at cycle 0, AW/W at 1, B at 2, rsp_valid at 3, cmd_ready at 4.
  - Read: accept at 0, AR at 1, R at 2, rsp_valid at 3.
- Watchdog:
  - Counter clears on accept and counts every cycle in WR, WR_B, AR, RD.
  - Counter saturates; timeout asserts when count == TIMEOUT_CYCLES and stays high until the next accept.
  - The transaction is never aborted (AXI rule); busy stays high.
- Address low bits pass through unmodified; no alignment check.
- SLVERR/DECERR are reported verbatim in rsp_resp; the master takes no other action on them.

Test Plan:
1. Write addr 0x08, data 0xA5A5_1234, wstrb 0xF, zero-wait slave -> AW and W handshake cycle 1, BREADY cycle 2, rsp_valid cycle 3 with resp=00 and rdata=0; a following read of 0x08 returns 0xA5A5_1234.
2. Read addr 0x00 from regfile -> rsp_rdata=0xDEADBEEF, rsp_resp=00; read addr 0x04 -> 0x76543210.
3. Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID low from cycle 2, AWVALID held with stable address until cycle 4, single B accepted; then repeat with W delayed and AW immediate.
4. Slave returns RRESP=10 and BRESP=11 -> rsp_resp=10 / 11 reported; the next command is accepted normally.
5. rsp_ready held low 5 cycles -> rsp_valid and rsp data stable, cmd_ready=0 throughout; cmd_valid presented meanwhile is not accepted until the cycle after the rsp handshake.
6. TIMEOUT_CYCLES=8 with ARREADY stuck low -> timeout=1 after 8 cycles and ARVALID still 1; then assert M_AXI_ARESETN=0 mid-transaction -> ARVALID=0 and state IDLE immediately, timeout=0, no rsp_valid after reset release.
